// File: rtl/seg7_scan4.sv
// Four-digit multiplexed common-anode 7-segment driver with a one-cycle blank gap between digits.
// Optional leading-zero suppression is built when LZ_BLANK_EN is defined.
module seg7_scan4 #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] DIG,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK,
    output logic [7:0]  nSEG,
    output logic [3:0]  nAN,
    output logic        FRAME
);

    typedef enum logic {StGap, StDrive} phase_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    phase_e           phase_q, phase_d;
    logic             tick_q, tick_d;
    logic [7:0]       nseg_q, nseg_d;
    logic [3:0]       nan_q, nan_d;
    logic             frame_q, frame_d;
    logic [15:0]      dig_q, dig_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;

    logic             tick;
    logic [3:0]       cur_digit;
    logic [3:0]       lz_sup;
    logic [7:0]       seg_val;

    function automatic logic [6:0] decode_bcd(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1011000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

`ifdef LZ_BLANK_EN
    // A digit is dark only while it and every digit to its left are zero.
    assign lz_sup[3] = (dig_q[15:12] == 4'd0);
    assign lz_sup[2] = (dig_q[15:8] == 8'd0);
    assign lz_sup[1] = (dig_q[15:4] == 12'd0);
    assign lz_sup[0] = 1'b0;
`else
    assign lz_sup = 4'b0000;
`endif

    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            2'd0:    cur_digit = dig_q[3:0];
            2'd1:    cur_digit = dig_q[7:4];
            2'd2:    cur_digit = dig_q[11:8];
            default: cur_digit = dig_q[15:12];
        endcase

        seg_val = {~dp_q[idx_q], decode_bcd(cur_digit)};
        if (blank_q[idx_q]) begin
            seg_val = 8'hFF;
        end else if (lz_sup[idx_q]) begin
            seg_val = {~dp_q[idx_q], 7'h7F};
        end
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        tick_d  = tick;
        idx_d   = idx_q;
        phase_d = phase_q;
        nseg_d  = nseg_q;
        nan_d   = nan_q;
        frame_d = 1'b0;
        dig_d   = dig_q;
        dp_d    = dp_q;
        blank_d = blank_q;

        if (LOAD) begin
            dig_d   = DIG;
            dp_d    = DP_IN;
            blank_d = BLANK;
        end

        if (tick) begin
            idx_d   = idx_q + 2'd1;
            nan_d   = 4'hF;
            nseg_d  = 8'hFF;
            phase_d = StGap;
            frame_d = (idx_q == 2'd3);
        end else if (phase_q == StDrive) begin
            nseg_d = seg_val;
        end else if (tick_q) begin
            // GAP only opens into DRIVE right after a tick, so nothing lights before the first slot.
            phase_d = StDrive;
            nan_d   = ~(4'b0001 << idx_q);
            nseg_d  = seg_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            idx_q   <= 2'd3;
            phase_q <= StGap;
            nseg_q  <= 8'hFF;
            nan_q   <= 4'hF;
            frame_q <= 1'b0;
            dig_q   <= 16'h0000;
            dp_q    <= 4'h0;
            blank_q <= 4'hF;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            nseg_q  <= nseg_d;
            nan_q   <= nan_d;
            frame_q <= frame_d;
            dig_q   <= dig_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
        end
    end

    assign nSEG  = nseg_q;
    assign nAN   = nan_q;
    assign FRAME = frame_q;

endmodule
